// File: rtl/sipo_frame.sv
// rtl/sipo_frame.sv - parametrised serial-in parallel-out deserializer with valid/ready word output
// Optional even-parity trailer bit is built when SIPO_PARITY_EN is defined.
module sipo_frame #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+2)-1:0]   bit_count,
  output logic                         overrun,
  output logic                         parity_err
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);
  localparam logic [CW-1:0] DATA_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] word_d;
  logic             shift_en;
  logic             complete;

  // Next shift value, data-bit qualification and frame completion detect
  always_comb begin
    sh_shifted = MSB_FIRST ? {sh[WIDTH-2:0], serial_in} : {serial_in, sh[WIDTH-1:1]};
    shift_en   = serial_valid && (bit_count < DATA_MAX);
    complete   = serial_valid && (bit_count == LAST_BIT);
`ifdef SIPO_PARITY_EN
    // Last bit is the parity bit, so the data word is already fully shifted in
    word_d     = sh;
`else
    // Last bit is a data bit and must be folded into the published word
    word_d     = sh_shifted;
`endif
  end

  // Shift register, frame counter, output holding register and sticky overrun
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      sh           <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (shift_en) begin
        sh <= sh_shifted;
      end
      if (serial_valid) begin
        bit_count <= complete ? '0 : bit_count + CW'(1);
      end
      if (complete) begin
        parallel_out <= word_d;
        out_valid    <= 1'b1;
        // Only an unaccepted pending word counts as lost
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  // Even-parity result captured alongside each completed word
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      parity_err <= 1'b0;
    end else if (complete) begin
      parity_err <= (^sh) ^ serial_in;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame.sv
// tb/tb_sipo_frame.sv - scoreboard bench for sipo_frame (8-bit MSB/LSB-first and 4-bit instances)
`timescale 1ns/1ps
module tb_sipo_frame;

`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL8 = PAR_EN ? 9 : 8;
  localparam int FL4 = PAR_EN ? 5 : 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, clear8, s8_in, s8_v, ready8;
  logic       clear4, s4_in, s4_v, ready4;
  logic [7:0] m8_po, l8_po;
  logic [3:0] m8_bc, l8_bc;
  logic       m8_ov, l8_ov, m8_or, l8_or, m8_pe, l8_pe;
  logic [3:0] m4_po;
  logic [2:0] m4_bc;
  logic       m4_ov, m4_or, m4_pe;

  int total = 0;
  int bad   = 0;
  logic [7:0] q_m8[$];
  logic [7:0] q_l8[$];
  logic [3:0] q_m4[$];
  logic [7:0] e8;
  logic [3:0] e4;

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .reset_n(reset_n), .clear(clear8), .serial_in(s8_in), .serial_valid(s8_v),
    .parallel_out(m8_po), .out_valid(m8_ov), .out_ready(ready8), .bit_count(m8_bc),
    .overrun(m8_or), .parity_err(m8_pe)
  );

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .reset_n(reset_n), .clear(clear8), .serial_in(s8_in), .serial_valid(s8_v),
    .parallel_out(l8_po), .out_valid(l8_ov), .out_ready(ready8), .bit_count(l8_bc),
    .overrun(l8_or), .parity_err(l8_pe)
  );

  sipo_frame #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .reset_n(reset_n), .clear(clear4), .serial_in(s4_in), .serial_valid(s4_v),
    .parallel_out(m4_po), .out_valid(m4_ov), .out_ready(ready4), .bit_count(m4_bc),
    .overrun(m4_or), .parity_err(m4_pe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake that will be taken at the next edge pops one expected word
  always @(negedge clk) begin
    if (reset_n && !clear8 && m8_ov && ready8) begin
      total++;
      if (q_m8.size() == 0) begin
        bad++;
        $display("FAIL sb_m8 unexpected word actual=%0h required=none", m8_po);
      end else begin
        e8 = q_m8.pop_front();
        if (m8_po !== e8) begin
          bad++;
          $display("FAIL sb_m8 actual=%0h required=%0h", m8_po, e8);
        end
      end
    end
    if (reset_n && !clear8 && l8_ov && ready8) begin
      total++;
      if (q_l8.size() == 0) begin
        bad++;
        $display("FAIL sb_l8 unexpected word actual=%0h required=none", l8_po);
      end else begin
        e8 = q_l8.pop_front();
        if (l8_po !== e8) begin
          bad++;
          $display("FAIL sb_l8 actual=%0h required=%0h", l8_po, e8);
        end
      end
    end
    if (reset_n && !clear4 && m4_ov && ready4) begin
      total++;
      if (q_m4.size() == 0) begin
        bad++;
        $display("FAIL sb_m4 unexpected word actual=%0h required=none", m4_po);
      end else begin
        e4 = q_m4.pop_front();
        if (m4_po !== e4) begin
          bad++;
          $display("FAIL sb_m4 actual=%0h required=%0h", m4_po, e4);
        end
      end
    end
  end

  // seq[7] is sent first; par is the trailing parity bit when parity is built
  task automatic send_frame8(input logic [7:0] seq, input logic par, input bit chk_gap);
    for (int k = 1; k <= FL8; k++) begin
      if (chk_gap && k == FL8) chk("gap_valid8", m8_ov, 0);
      s8_in = (k <= 8) ? seq[8-k] : par;
      s8_v  = 1'b1;
      tick();
      chk("bit_count8", m8_bc, (k == FL8) ? 0 : k);
    end
  endtask

  task automatic frame8_done(input logic [7:0] exp_m, input logic [7:0] exp_l, input logic perr);
    chk("out_valid8", m8_ov, 1);
    chk("word_msb8", m8_po, exp_m);
    chk("word_lsb8", l8_po, exp_l);
    chk("parity_m8", m8_pe, perr);
    chk("parity_l8", l8_pe, perr);
  endtask

  task automatic send4(input logic [3:0] w, input bit gap, input bit ready_last);
    for (int k = 1; k <= FL4; k++) begin
      if (ready_last && k == FL4) ready4 = 1'b1;
      s4_in = (k <= 4) ? w[4-k] : ^w;
      s4_v  = 1'b1;
      tick();
      chk("bit_count4", m4_bc, (k == FL4) ? 0 : k);
      if (gap && k < FL4) begin
        s4_v = 1'b0;
        tick();
        chk("bit_count4_gap", m4_bc, k);
      end
    end
  endtask

  task automatic partial8();
    for (int k = 1; k <= 3; k++) begin
      s8_in = k[0];
      s8_v  = 1'b1;
      tick();
    end
    s8_v = 1'b0;
    chk("mid_count8", m8_bc, 3);
    chk("mid_overrun8", m8_or, 1);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_po"}, m8_po, 0);
    chk({tag, "_ov"}, m8_ov, 0);
    chk({tag, "_bc"}, m8_bc, 0);
    chk({tag, "_or"}, m8_or, 0);
    chk({tag, "_pe"}, m8_pe, 0);
    chk({tag, "_lpo"}, l8_po, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; clear8 = 1'b0; s8_in = 1'b0; s8_v = 1'b0; ready8 = 1'b0;
    clear4 = 1'b0; s4_in = 1'b0; s4_v = 1'b0; ready4 = 1'b0;
    tick();
    tick();
    chk_zero8("rst");
    chk("rst_po4", m4_po, 0);
    chk("rst_ov4", m4_ov, 0);
    chk("rst_bc4", m4_bc, 0);

    // Mid-frame reset with a pending word and overrun set
    reset_n = 1'b1;
    tick();
    send_frame8(8'hB2, 1'b0, 1'b0);
    send_frame8(8'h3C, 1'b0, 1'b0);
    partial8();
    reset_n = 1'b0;
    tick();
    tick();
    chk_zero8("rst_mid");
    reset_n = 1'b1;
    tick();
    tick();
    chk("rst_release_ov", m8_ov, 0);

    // Same abort using clear
    send_frame8(8'hB2, 1'b0, 1'b0);
    send_frame8(8'h3C, 1'b0, 1'b0);
    partial8();
    clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    chk_zero8("clr_mid");
    tick();
    chk("clr_release_ov", m8_ov, 0);

    // Bit order: 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
    ready8 = 1'b1;
    q_m8.push_back(8'hB2); q_l8.push_back(8'h4D);
    send_frame8(8'hB2, 1'b0, 1'b0);
    frame8_done(8'hB2, 8'h4D, 1'b0);
    s8_v = 1'b0;
    tick();
    chk("accept_clears8", m8_ov, 0);
    chk("word_held8", m8_po, 8'hB2);

    // Wrong parity bit: error only when parity is built
    q_m8.push_back(8'hB2); q_l8.push_back(8'h4D);
    send_frame8(8'hB2, 1'b1, 1'b0);
    frame8_done(8'hB2, 8'h4D, PAR_EN);
    s8_v = 1'b0;
    tick();
    chk("perr_held8", m8_pe, PAR_EN);

    // Throughput: back-to-back frames with no dead cycles
    q_m8.push_back(8'hA5); q_l8.push_back(8'hA5);
    send_frame8(8'hA5, 1'b0, 1'b1);
    frame8_done(8'hA5, 8'hA5, 1'b0);
    q_m8.push_back(8'h3C); q_l8.push_back(8'h3C);
    send_frame8(8'h3C, 1'b0, 1'b1);
    frame8_done(8'h3C, 8'h3C, 1'b0);
    q_m8.push_back(8'hFF); q_l8.push_back(8'hFF);
    send_frame8(8'hFF, 1'b0, 1'b1);
    frame8_done(8'hFF, 8'hFF, 1'b0);
    s8_v = 1'b0;
    tick();
    chk("tp_drained", m8_ov, 0);

    // Gapped input on the 4-bit instance
    ready4 = 1'b1;
    q_m4.push_back(4'hD);
    send4(4'hD, 1'b1, 1'b0);
    chk("gap_valid4", m4_ov, 1);
    chk("gap_word4", m4_po, 4'hD);
    s4_v = 1'b0;
    tick();
    chk("gap_valid4_once", m4_ov, 0);

    // Overrun: two frames with no acceptance
    ready4 = 1'b0;
    send4(4'h9, 1'b0, 1'b0);
    chk("ovr_first_valid", m4_ov, 1);
    chk("ovr_first_word", m4_po, 4'h9);
    chk("ovr_first_flag", m4_or, 0);
    chk("ovr_first_perr", m4_pe, 0);
    send4(4'h6, 1'b0, 1'b0);
    chk("ovr_second_word", m4_po, 4'h6);
    chk("ovr_second_flag", m4_or, 1);
    s4_v = 1'b0;
    tick();
    tick();
    chk("ovr_sticky", m4_or, 1);
    q_m4.push_back(4'h6);
    ready4 = 1'b1;
    tick();
    chk("ovr_accept_valid", m4_ov, 0);
    chk("ovr_sticky_after_accept", m4_or, 1);
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    chk("clr_overrun4", m4_or, 0);
    chk("clr_word4", m4_po, 0);

    // Accept and complete in the same cycle: no overrun
    ready4 = 1'b0;
    q_m4.push_back(4'hA);
    q_m4.push_back(4'h5);
    send4(4'hA, 1'b0, 1'b0);
    send4(4'h5, 1'b0, 1'b1);
    chk("same_cycle_valid", m4_ov, 1);
    chk("same_cycle_word", m4_po, 4'h5);
    chk("same_cycle_overrun", m4_or, 0);
    s4_v = 1'b0;
    tick();
    chk("same_cycle_drained", m4_ov, 0);

    tick();
    chk("sb_drain", q_m8.size() + q_l8.size() + q_m4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
